ifu_fetch: RTL and testbench

//  Instruction fetch unit: the producer of the 32-bit instruction word that the decode stage consumes.
//  - Holds the fetch PC and issues word reads to instruction memory over a valid/ready request channel.
//  - Collects in-order responses into a small FIFO tagged with their PC.
//  - Hands instructions downstream over a valid/ready handshake.
//  - Supports a branch/jump redirect that flushes everything in flight.

---
 rtl/ifu_fetch.sv | 139 +++++++++++++
 tb/tb_ifu_fetch.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: PC generation, credit-limited instruction memory requests,
// an in-order response FIFO, and redirect flush with draining of stale responses.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   out_q, out_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [31:0]     data_q [FIFO_DEPTH];
  logic [31:0]     pcs_q  [FIFO_DEPTH];

  logic            run;
  logic [CW:0]     credit_used;
  logic            req_fire;
  logic            rsp_take;
  logic            push;
  logic            pop;
  logic [CW-1:0]   out_after_rsp;
  logic [31:0]     redirect_tgt;

  assign run          = (state_q == ST_RUN);
  assign credit_used  = {1'b0, count_q} + {1'b0, out_q};
  assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;

  // Credits count both buffered words and requests still in flight, so a
  // response always finds a free FIFO slot.
  assign imem_req_valid = !rst && run && !redirect_valid && (credit_used < DEPTH_C);
  assign imem_req_addr  = pc_q;

  assign inst_valid = !rst && run && (count_q != '0);
  assign inst_o     = data_q[rd_ptr_q];
  assign inst_pc    = pcs_q[rd_ptr_q];

  assign req_fire      = imem_req_valid && imem_req_ready;
  assign rsp_take      = imem_rsp_valid && (out_q != '0);
  assign push          = rsp_take && run && !redirect_valid;
  assign pop           = inst_valid && inst_ready && !redirect_valid;
  assign out_after_rsp = out_q - CW'(rsp_take);

  // NOTE: every variable gets its default at the top of always_comb so no path
  // can leave it unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    rsp_pc_d = rsp_pc_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    out_d    = out_after_rsp + CW'(req_fire);

    if (redirect_valid) begin
      pc_d     = redirect_tgt;
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      if (out_after_rsp != '0) begin
        state_d = ST_DRAIN;
      end else begin
        state_d  = ST_RUN;
        rsp_pc_d = redirect_tgt;
      end
    end else if (!run) begin
      // Stale responses are dropped; resume once the last one has returned.
      if (out_after_rsp == '0) begin
        state_d  = ST_RUN;
        rsp_pc_d = pc_q;
      end
    end else begin
      if (req_fire) pc_d = pc_q + 32'd4;
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
        rsp_pc_d = rsp_pc_q + 32'd4;
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      pc_q     <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      count_q  <= '0;
      out_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      count_q  <= count_d;
      out_q    <= out_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // NOTE: the storage array is not reset; count_q qualifies every entry, so
  // resetting the data would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_ptr_q] <= imem_rsp_data;
      pcs_q[wr_ptr_q]  <= rsp_pc_q;
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: memory model with configurable latency feeding a
// scoreboard of expected {pc, word} pairs, plus a second instance for PC wrap.
module tb_ifu_fetch;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  typedef struct packed {
    int unsigned due;
    logic [31:0] addr;
  } pend_t;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst_o;
  logic [31:0] inst_pc;
  logic        inst_ready;

  logic        rst_w;
  logic        w_req_valid;
  logic [31:0] w_req_addr;
  logic        w_rsp_valid;
  logic [31:0] w_rsp_data;
  logic        w_inst_valid;
  logic [31:0] w_inst_o;
  logic [31:0] w_inst_pc;

  int          n_total = 0;
  int          n_bad   = 0;
  int          hs_cnt  = 0;
  int          acc_cnt = 0;
  int unsigned edge_n  = 0;
  int unsigned mem_lat = 1;
  logic [31:0] exp_addr = 32'h0;
  exp_t        exp_q[$];
  pend_t       pend_q[$];
  exp_t        mon_e;
  pend_t       new_p;

  logic        w_pend = 1'b0;
  logic [31:0] w_pend_addr = 32'h0;
  logic [31:0] w_addr_exp[$];
  logic [31:0] w_pc_exp[$];

  ifu_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(4)) u_dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_o         (inst_o),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready)
  );

  ifu_fetch #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) u_wrap (
    .clk            (clk),
    .rst            (rst_w),
    .imem_req_valid (w_req_valid),
    .imem_req_addr  (w_req_addr),
    .imem_req_ready (1'b1),
    .imem_rsp_valid (w_rsp_valid),
    .imem_rsp_data  (w_rsp_data),
    .redirect_valid (1'b0),
    .redirect_pc    (32'h0),
    .inst_valid     (w_inst_valid),
    .inst_o         (w_inst_o),
    .inst_pc        (w_inst_pc),
    .inst_ready     (1'b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  function automatic logic [31:0] img(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h3C5A_96E1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Memory model: in-order responses after mem_lat edges; each accept queues
  // the word the bench expects to see delivered.
  always @(negedge clk) begin
    #1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    if (pend_q.size() > 0 && pend_q[0].due <= edge_n + 1) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = img(pend_q[0].addr);
      void'(pend_q.pop_front());
    end
    if (imem_req_valid === 1'b1 && imem_req_ready === 1'b1) begin
      check("req_addr", imem_req_addr, exp_addr);
      new_p.due  = edge_n + 1 + mem_lat;
      new_p.addr = imem_req_addr;
      pend_q.push_back(new_p);
      exp_q.push_back({exp_addr, img(exp_addr)});
      exp_addr = exp_addr + 32'd4;
      acc_cnt++;
    end
  end

  always @(negedge clk) begin
    #2;
    if (inst_valid === 1'b1 && inst_ready === 1'b1 && redirect_valid === 1'b0) begin
      hs_cnt++;
      if (exp_q.size() == 0) begin
        check("inst_unexpected", 32'(exp_q.size()), 32'd1);
      end else begin
        mon_e = exp_q.pop_front();
        check("inst_pc", inst_pc, mon_e.pc);
        check("inst_o", inst_o, mon_e.data);
      end
    end
  end

  // Wrap instance: always-ready memory with one-cycle latency.
  always @(negedge clk) begin
    #1;
    w_rsp_valid = w_pend;
    w_rsp_data  = img(w_pend_addr);
    w_pend      = (w_req_valid === 1'b1);
    w_pend_addr = w_req_addr;
    if (w_req_valid === 1'b1 && w_addr_exp.size() > 0)
      check("wrap_req_addr", w_req_addr, w_addr_exp.pop_front());
  end

  always @(negedge clk) begin
    #2;
    if (w_inst_valid === 1'b1 && w_pc_exp.size() > 0) begin
      check("wrap_inst_pc", w_inst_pc, w_pc_exp[0]);
      check("wrap_inst_o", w_inst_o, img(w_pc_exp[0]));
      void'(w_pc_exp.pop_front());
    end
  end

  initial begin
    rst            = 1'b1;
    rst_w          = 1'b1;
    imem_req_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    inst_ready     = 1'b1;
    mem_lat        = 1;

    // 1: reset, then streaming with a ready memory and ready decode
    repeat (3) begin
      tick(); #3;
      check("rst_req_valid", 32'(imem_req_valid), 32'd0);
      check("rst_inst_valid", 32'(inst_valid), 32'd0);
    end
    tick();
    rst = 1'b0; exp_q.delete(); exp_addr = 32'h0; hs_cnt = 0;
    #3;
    check("first_req_valid", 32'(imem_req_valid), 32'd1);
    check("first_req_addr", imem_req_addr, 32'h0);
    repeat (30) tick();
    #3;
    check("t1_throughput", 32'(hs_cnt), 32'd29);

    // 2: decode stalled; requests stop at FIFO_DEPTH, head holds
    tick(); rst = 1'b1; inst_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0; exp_q.delete(); exp_addr = 32'h0; hs_cnt = 0; acc_cnt = 0;
    for (int j = 1; j <= 10; j++) begin
      tick(); #3;
      if (j >= 3) begin
        check("t2_hold_valid", 32'(inst_valid), 32'd1);
        check("t2_hold_pc", inst_pc, 32'h0);
        check("t2_hold_inst", inst_o, img(32'h0));
      end
    end
    check("t2_accepts", 32'(acc_cnt), 32'd4);
    check("t2_req_blocked", 32'(imem_req_valid), 32'd0);
    tick(); inst_ready = 1'b1; hs_cnt = 0;
    repeat (20) tick();
    #3;
    check("t2_resume", 32'(hs_cnt >= 15), 32'd1);

    // 3: redirect with two requests outstanding and 3-cycle responses
    tick(); rst = 1'b1; mem_lat = 3;
    repeat (3) tick();
    rst = 1'b0; exp_q.delete(); exp_addr = 32'h0;
    tick();
    tick();
    imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_1002;
    exp_q.delete(); exp_addr = 32'h0000_1000;
    #3;
    check("t3_redir_no_req", 32'(imem_req_valid), 32'd0);
    tick();
    redirect_valid = 1'b0; imem_req_ready = 1'b1; mem_lat = 1;
    repeat (2) begin
      #3;
      check("t3_drain_no_req", 32'(imem_req_valid), 32'd0);
      check("t3_drain_no_inst", 32'(inst_valid), 32'd0);
      tick();
    end
    #3;
    check("t3_resume_valid", 32'(imem_req_valid), 32'd1);
    check("t3_resume_addr", imem_req_addr, 32'h0000_1000);
    hs_cnt = 0;
    repeat (15) tick();
    #3;
    check("t3_delivered", 32'(hs_cnt >= 5), 32'd1);

    // 4: redirect coincident with a response and a handshake
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_2003;
    exp_q.delete(); exp_addr = 32'h0000_2000;
    #3;
    check("t4_head_valid", 32'(inst_valid), 32'd1);
    check("t4_no_req", 32'(imem_req_valid), 32'd0);
    tick();
    redirect_valid = 1'b0;
    #3;
    check("t4_flushed", 32'(inst_valid), 32'd0);
    check("t4_req_valid", 32'(imem_req_valid), 32'd1);
    check("t4_req_addr", imem_req_addr, 32'h0000_2000);
    hs_cnt = 0;
    repeat (10) tick();
    #3;
    check("t4_delivered", 32'(hs_cnt >= 5), 32'd1);

    // 6: one-cycle reset with buffered words and requests in flight
    tick(); rst = 1'b1; mem_lat = 3; inst_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0; exp_q.delete(); exp_addr = 32'h0; acc_cnt = 0;
    repeat (4) tick();
    #3;
    check("t6_buffered", 32'(inst_valid), 32'd1);
    tick();
    rst = 1'b1; exp_q.delete(); exp_addr = 32'h0;
    #3;
    check("t6_rst_inst_valid", 32'(inst_valid), 32'd0);
    check("t6_rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("t6_accepts", 32'(acc_cnt), 32'd4);
    tick();
    rst = 1'b0; inst_ready = 1'b1;
    #3;
    check("t6_empty_after_rst", 32'(inst_valid), 32'd0);
    check("t6_restart_valid", 32'(imem_req_valid), 32'd1);
    check("t6_restart_addr", imem_req_addr, 32'h0);
    repeat (3) begin
      tick(); #3;
      check("t6_late_rsp_ignored", 32'(inst_valid), 32'd0);
    end
    tick(); #3;
    check("t6_first_valid", 32'(inst_valid), 32'd1);
    check("t6_first_pc", inst_pc, 32'h0);
    check("t6_first_inst", inst_o, img(32'h0));

    // 5: PC wrap from RESET_PC = FFFF_FFF8
    tick();
    w_addr_exp = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    w_pc_exp   = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    rst_w = 1'b0;
    #3;
    check("wrap_first_valid", 32'(w_req_valid), 32'd1);
    repeat (20) tick();
    #3;
    check("wrap_addrs_seen", 32'(w_addr_exp.size()), 32'd0);
    check("wrap_insts_seen", 32'(w_pc_exp.size()), 32'd0);

    tick();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
